// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the bypassed multi-port register file.
//   RF_WIDTH / RF_NREGS / RF_NREAD : default data width, register count and
//                                    read-port count.
//   rf_selw(nregs)                 : width of a register select (clog2).
//   rf_sel_t                       : select index type for the default size.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_NREAD = 2;

    // A select always needs at least one bit, even for tiny register files.
    function automatic int rf_selw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    typedef logic [$clog2(RF_NREGS)-1:0] rf_sel_t;

endpackage

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of regfile_bypass_mp.
// Optional feature macro: REGFILE_BYPASS_EN (adds the write-to-read bypass).
//
// Ports:
//   i_wr0_ok/i_wr0_sel/i_wr0_data : qualified write port 0 (bypass builds only)
//   i_wr1_ok/i_wr1_sel/i_wr1_data : qualified write port 1 (bypass builds only)
//   i_sel    : register select for this port
//   i_regs   : flattened storage, register r at [r*WIDTH +: WIDTH]
//   o_data   : read data
//   o_oor    : select is beyond the last register
//
// The *_ok inputs are already qualified by the parent (enable, reset, range
// and zero-register checks), so a dropped write can never bypass.
// -----------------------------------------------------------------------------
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NREGS    = RF_NREGS,
    parameter int ZERO_REG = 0,
    localparam int SELW    = rf_selw(NREGS)
) (
`ifdef REGFILE_BYPASS_EN
    input  logic             i_wr0_ok,
    input  logic [SELW-1:0]  i_wr0_sel,
    input  logic [WIDTH-1:0] i_wr0_data,
    input  logic             i_wr1_ok,
    input  logic [SELW-1:0]  i_wr1_sel,
    input  logic [WIDTH-1:0] i_wr1_data,
`endif
    input  logic [SELW-1:0]        i_sel,
    input  logic [NREGS*WIDTH-1:0] i_regs,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_oor
);

    logic             w_oor;
    logic             w_zero_hit;
    logic [WIDTH-1:0] w_stored;

    // With a power-of-two register count every select encoding is valid.
    generate
        if (NREGS == (1 << SELW)) begin : g_full_range
            assign w_oor = 1'b0;
        end else begin : g_partial_range
            assign w_oor = (i_sel >= SELW'(NREGS));
        end
    endgenerate

    assign w_zero_hit = (ZERO_REG != 0) && (i_sel == '0);
    assign o_oor      = w_oor;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_stored = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (i_sel == SELW'(r)) begin
                w_stored = i_regs[r*WIDTH +: WIDTH];
            end
        end
    end

    // Later assignments win: stored < port 0 bypass < port 1 bypass < forced 0.
    always_comb begin
        o_data = w_stored;
`ifdef REGFILE_BYPASS_EN
        if (i_wr0_ok && (i_wr0_sel == i_sel)) begin
            o_data = i_wr0_data;
        end
        if (i_wr1_ok && (i_wr1_sel == i_sel)) begin
            o_data = i_wr1_data;
        end
`endif
        if (w_oor || w_zero_hit) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/regfile_bypass_mp.sv
// -----------------------------------------------------------------------------
// regfile_bypass_mp
// NREGS x WIDTH register file with NREAD combinational read ports and two
// write ports (port 0: ALU writeback, port 1: load/late writeback, port 1 wins
// on a same-register collision).
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a write is visible
// on matching read ports in the issuing cycle; otherwise reads return the
// stored value and new data appears one cycle later.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous reset, active low
//   readSel           packed read selects, port i at [i*SELW +: SELW]
//   readData          packed read data, port i at [i*WIDTH +: WIDTH]
//   wr0Sel/wr0Data/wr0En, wr1Sel/wr1Data/wr1En : write ports
//   err               collision or out-of-range select (forced low in reset)
// -----------------------------------------------------------------------------
module regfile_bypass_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NREGS    = RF_NREGS,
    parameter int NREAD    = RF_NREAD,
    parameter int ZERO_REG = 0,
    localparam int SELW    = rf_selw(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*SELW-1:0]  readSel,
    output logic [NREAD*WIDTH-1:0] readData,
    input  logic [SELW-1:0]        wr0Sel,
    input  logic [WIDTH-1:0]       wr0Data,
    input  logic                   wr0En,
    input  logic [SELW-1:0]        wr1Sel,
    input  logic [WIDTH-1:0]       wr1Data,
    input  logic                   wr1En,
    output logic                   err
);

    logic [WIDTH-1:0]       r_mem [NREGS];
    logic [NREGS*WIDTH-1:0] w_mem_flat;
    logic                   w_wr0_oor;
    logic                   w_wr1_oor;
    logic                   w_wr0_ok;
    logic                   w_wr1_ok;
    logic                   w_collision;
    logic [NREAD-1:0]       w_rd_oor;

    generate
        if (NREGS == (1 << SELW)) begin : g_full_range
            assign w_wr0_oor = 1'b0;
            assign w_wr1_oor = 1'b0;
        end else begin : g_partial_range
            assign w_wr0_oor = (wr0Sel >= SELW'(NREGS));
            assign w_wr1_oor = (wr1Sel >= SELW'(NREGS));
        end
    endgenerate

    // A write that survives these checks is stored and, if compiled in,
    // bypassed; everything else is dropped and never bypasses.
    assign w_wr0_ok = rst && wr0En && !w_wr0_oor && !((ZERO_REG != 0) && (wr0Sel == '0));
    assign w_wr1_ok = rst && wr1En && !w_wr1_oor && !((ZERO_REG != 0) && (wr1Sel == '0));

    // NOTE: the whole storage array is reset; a write issued in the reset
    // cycle is discarded because reset takes the first branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; with both ports on one register
            // the later statement (port 1) is the one that lands.
            if (w_wr0_ok) begin
                r_mem[wr0Sel] <= wr0Data;
            end
            if (w_wr1_ok) begin
                r_mem[wr1Sel] <= wr1Data;
            end
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_flat
        assign w_mem_flat[r*WIDTH +: WIDTH] = r_mem[r];
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        rf_read_port #(
            .WIDTH    (WIDTH),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
`ifdef REGFILE_BYPASS_EN
            .i_wr0_ok   (w_wr0_ok),
            .i_wr0_sel  (wr0Sel),
            .i_wr0_data (wr0Data),
            .i_wr1_ok   (w_wr1_ok),
            .i_wr1_sel  (wr1Sel),
            .i_wr1_data (wr1Data),
`endif
            .i_sel      (readSel[p*SELW +: SELW]),
            .i_regs     (w_mem_flat),
            .o_data     (readData[p*WIDTH +: WIDTH]),
            .o_oor      (w_rd_oor[p])
        );
    end

    assign w_collision = wr0En && wr1En && (wr0Sel == wr1Sel);

    assign err = rst && (w_collision
                      || (wr0En && w_wr0_oor)
                      || (wr1En && w_wr1_oor)
                      || (|w_rd_oor));

endmodule

// File: tb/tb_regfile_bypass_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_bypass_mp
// Directed bench for regfile_bypass_mp. Three instances share all inputs:
//   u_a : default configuration (8 registers, no zero register)
//   u_z : ZERO_REG = 1
//   u_o : NREGS = 6 (select 6/7 out of range)
// Expected values are hand computed and follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_bypass_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [5:0]  readSel;
    logic [2:0]  wr0Sel, wr1Sel;
    logic [15:0] wr0Data, wr1Data;
    logic        wr0En, wr1En;
    logic [31:0] rd_a, rd_z, rd_o;
    logic        err_a, err_z, err_o;

    int n_checks = 0;
    int n_errors = 0;

    regfile_bypass_mp u_a (
        .clk(clk), .rst(rst), .readSel(readSel), .readData(rd_a),
        .wr0Sel(wr0Sel), .wr0Data(wr0Data), .wr0En(wr0En),
        .wr1Sel(wr1Sel), .wr1Data(wr1Data), .wr1En(wr1En), .err(err_a)
    );

    regfile_bypass_mp #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .readSel(readSel), .readData(rd_z),
        .wr0Sel(wr0Sel), .wr0Data(wr0Data), .wr0En(wr0En),
        .wr1Sel(wr1Sel), .wr1Data(wr1Data), .wr1En(wr1En), .err(err_z)
    );

    regfile_bypass_mp #(.NREGS(6)) u_o (
        .clk(clk), .rst(rst), .readSel(readSel), .readData(rd_o),
        .wr0Sel(wr0Sel), .wr0Data(wr0Data), .wr0En(wr0En),
        .wr1Sel(wr1Sel), .wr1Data(wr1Data), .wr1En(wr1En), .err(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 more unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic e0, input logic [2:0] s0, input logic [15:0] d0,
                          input logic e1, input logic [2:0] s1, input logic [15:0] d1);
        wr0En = e0; wr0Sel = s0; wr0Data = d0;
        wr1En = e1; wr1Sel = s1; wr1Data = d1;
    endtask

    task automatic set_rd(input logic [2:0] p0, input logic [2:0] p1);
        readSel = {p1, p0};
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_o [6];

        rst = 1'b0;
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        readSel = '0;
        repeat (2) @(posedge clk);
        #1;
        set_rd(0, 1);
        check("reset_rd", rd_a, 32'h0);
        check("reset_err", err_a, 0);

        // Reset wins over a write in the same edge.
        rst = 1'b1;
        set_wr(1, 3, 16'hBEEF, 0, 0, 16'h0);
        set_rd(3, 0);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(3, 0);
        check("r3_beef", rd_a[15:0], 16'hBEEF);
        rst = 1'b0;
        set_wr(1, 3, 16'h1234, 0, 0, 16'h0);
        set_rd(3, 0);
        check("rst_low_stored", rd_a[15:0], 16'hBEEF);
        check("rst_low_err", err_a, 0);
        next_cycle();
        rst = 1'b1;
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(3, 0);
        check("r3_after_reset", rd_a[15:0], 16'h0000);
        check("err_after_reset", err_a, 0);

        // Preload R2 through port 1.
        set_wr(0, 0, 16'h0, 1, 2, 16'h5A5A);
        set_rd(0, 2);
        check("r2_bypass", rd_a[31:16], BYP ? 16'h5A5A : 16'h0000);
        next_cycle();

        // Same-cycle bypass on port 0.
        set_wr(1, 5, 16'hA5A5, 0, 0, 16'h0);
        set_rd(5, 2);
        check("r5_bypass", rd_a[15:0], BYP ? 16'hA5A5 : 16'h0000);
        check("r2_stored", rd_a[31:16], 16'h5A5A);
        check("bypass_err", err_a, 0);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(5, 2);
        check("r5_stored", rd_a[15:0], 16'hA5A5);

        // Write collision on R4.
        set_wr(1, 4, 16'h1111, 1, 4, 16'h2222);
        set_rd(4, 5);
        check("col_err", err_a, 1);
        check("col_rd", rd_a[15:0], BYP ? 16'h2222 : 16'h0000);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(4, 5);
        check("col_stored", rd_a[15:0], 16'h2222);
        check("col_err_clear", err_a, 0);

        // Dual independent writes.
        set_wr(1, 1, 16'h0F0F, 1, 6, 16'hF0F0);
        set_rd(1, 6);
        check("dual_p0", rd_a[15:0], BYP ? 16'h0F0F : 16'h0000);
        check("dual_p1", rd_a[31:16], BYP ? 16'hF0F0 : 16'h0000);
        check("dual_err", err_a, 0);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(1, 6);
        check("dual_stored", rd_a, 32'hF0F0_0F0F);

        // Back-to-back writes to R7.
        set_wr(1, 7, 16'h0001, 0, 0, 16'h0);
        set_rd(7, 7);
        check("b2b_first", rd_a[15:0], BYP ? 16'h0001 : 16'h0000);
        next_cycle();
        set_wr(1, 7, 16'h0002, 0, 0, 16'h0);
        set_rd(7, 7);
        check("b2b_second", rd_a[15:0], BYP ? 16'h0002 : 16'h0001);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(7, 7);
        check("b2b_stored", rd_a[15:0], 16'h0002);

        // Zero register: u_z drops the write, u_a stores it.
        set_wr(1, 0, 16'hFFFF, 0, 0, 16'h0);
        set_rd(0, 0);
        check("zr_same", rd_z[15:0], 16'h0000);
        check("zr_err", err_z, 0);
        check("r0_plain_same", rd_a[15:0], BYP ? 16'hFFFF : 16'h0000);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        set_rd(0, 0);
        check("zr_next", rd_z[15:0], 16'h0000);
        check("r0_plain_next", rd_a[15:0], 16'hFFFF);

        // Out-of-range on the 6-register instance.
        set_wr(1, 6, 16'h7777, 0, 0, 16'h0);
        set_rd(7, 4);
        check("oor_rd", rd_o[15:0], 16'h0000);
        check("oor_other_port", rd_o[31:16], 16'h2222);
        check("oor_err", err_o, 1);
        check("inrange_err", err_a, 0);
        next_cycle();
        set_wr(0, 0, 16'h0, 0, 0, 16'h0);
        exp_o[0] = 16'hFFFF; exp_o[1] = 16'h0F0F; exp_o[2] = 16'h5A5A;
        exp_o[3] = 16'h0000; exp_o[4] = 16'h2222; exp_o[5] = 16'hA5A5;
        for (int r = 0; r < 6; r++) begin
            set_rd(3'(r), 3'(r));
            check($sformatf("oor_keep_r%0d", r), rd_o[15:0], exp_o[r]);
        end

        // err is held low during reset, and all registers clear afterwards.
        rst = 1'b0;
        set_rd(7, 7);
        check("rst_err_masked", err_o, 0);
        next_cycle();
        rst = 1'b1;
        set_rd(1, 5);
        check("final_reset_rd", rd_a, 32'h0);
        check("final_reset_err", err_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
